// File: rtl/apresentador_pkg.sv
// Shared definitions for the question-presentation sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apresentador_pkg;

  // Sequencer states. The code doubles as the debug state code.
  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BUSCA   = 3'd1,
    CARREGA = 3'd2,
    LIGA    = 3'd3,
    DESLIGA = 3'd4,
    AVANCA  = 3'd5,
    FIM     = 3'd6
  } estado_t;

  // Debug code reported while the state register holds an unused encoding.
  localparam logic [3:0] DB_ILEGAL = 4'hF;

  // Display timing for the real game.
  localparam int T_ON_PADRAO  = 1000;
  localparam int T_OFF_PADRAO = 500;

  // Short timing used in simulation so a full question fits in a few cycles.
  localparam int T_ON_SIM  = 4;
  localparam int T_OFF_SIM = 2;

  // Larger of two integers; sizes the shared LED timer.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apresentador_pergunta_temporizador_led.sv
// Cycle counter that flags the last cycle of a programmable interval.
// Latency: fim is combinational from the count register; the count updates one cycle after conta.
// Backpressure: none; zera has priority over conta.
module temporizador_led #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] contagem;

  // Counter: clear on zera, otherwise advance while conta is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= contagem + W'(1);
    end
  end

  assign fim = (contagem == (limite - W'(1)));

endmodule

// File: rtl/apresentador_pergunta.sv
// Walks the question ROM, lighting each entry for T_ON cycles then blanking for T_OFF, and pulses pronto at the end.
// Latency: T_ON+T_OFF+3 cycles per entry; pronto arrives N*(T_ON+T_OFF+3)+1 cycles after iniciar is sampled.
// Backpressure: none; iniciar is ignored while ocupado, abortar returns to idle on the next edge.
module apresentador_pergunta
  import apresentador_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int T_ON   = T_ON_PADRAO,
  parameter int T_OFF  = T_OFF_PADRAO
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] num_itens,
  output logic [ADDR_W-1:0] endereco,
  input  logic [DATA_W-1:0] dado_rom,
  output logic [DATA_W-1:0] leds,
  output logic              led_ativo,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  // One timer serves both intervals, so it is sized for the longer one.
  localparam int TW = $clog2(max2(T_ON, T_OFF)) + 1;

  estado_t           estado;
  estado_t           proximo;
  logic [ADDR_W-1:0] indice;
  logic [ADDR_W-1:0] ultimo_idx;
  logic [DATA_W-1:0] dado_reg;
  logic              zera_tmp;
  logic              conta_tmp;
  logic              fim_tmp;
  logic [TW-1:0]     limite_tmp;
  logic              inicia;
  logic              ultimo;

  // abortar wins over a simultaneous iniciar.
  assign inicia = iniciar & ~abortar;
  assign ultimo = (indice == ultimo_idx);

  // The interval being timed depends on which phase of the entry we are in.
  assign limite_tmp = (estado == DESLIGA) ? TW'(T_OFF) : TW'(T_ON);

  temporizador_led #(
    .W(TW)
  ) u_temporizador (
    .clock  (clock),
    .reset_n(reset_n),
    .zera   (zera_tmp),
    .conta  (conta_tmp),
    .limite (limite_tmp),
    .fim    (fim_tmp)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  // Next state and timer control; abortar overrides every non-idle transition.
  always_comb begin
    proximo   = estado;
    zera_tmp  = 1'b0;
    conta_tmp = 1'b0;
    case (estado)
      OCIOSO: begin
        if (inicia) begin
          proximo = BUSCA;
        end
      end
      BUSCA: begin
        proximo = CARREGA;
      end
      CARREGA: begin
        zera_tmp = 1'b1;
        proximo  = LIGA;
      end
      LIGA: begin
        if (fim_tmp) begin
          zera_tmp = 1'b1;
          proximo  = DESLIGA;
        end else begin
          conta_tmp = 1'b1;
        end
      end
      DESLIGA: begin
        if (fim_tmp) begin
          zera_tmp = 1'b1;
          proximo  = AVANCA;
        end else begin
          conta_tmp = 1'b1;
        end
      end
      AVANCA: begin
        proximo = ultimo ? FIM : BUSCA;
      end
      FIM: begin
        proximo = OCIOSO;
      end
      default: begin
        proximo = OCIOSO;
      end
    endcase
    if (abortar && (estado != OCIOSO)) begin
      proximo = OCIOSO;
    end
  end

  // Player-facing outputs decoded from the current state.
  always_comb begin
    leds      = '0;
    led_ativo = 1'b0;
    ocupado   = 1'b1;
    pronto    = 1'b0;
    db_estado = {1'b0, estado};
    case (estado)
      OCIOSO: begin
        ocupado = 1'b0;
      end
      LIGA: begin
        leds      = dado_reg;
        led_ativo = 1'b1;
      end
      FIM: begin
        pronto = 1'b1;
      end
      BUSCA, CARREGA, DESLIGA, AVANCA: begin
      end
      default: begin
        db_estado = DB_ILEGAL;
      end
    endcase
  end

  // Index and last-entry registers: loaded on start, index advances between entries and never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      indice     <= '0;
      ultimo_idx <= '0;
    end else if ((estado == OCIOSO) && inicia) begin
      indice     <= '0;
      ultimo_idx <= num_itens;
    end else if ((estado == AVANCA) && !ultimo && !abortar) begin
      indice <= indice + ADDR_W'(1);
    end
  end

  // Capture the ROM word in the cycle its read data is valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dado_reg <= '0;
    end else if (estado == CARREGA) begin
      dado_reg <= dado_rom;
    end
  end

  assign endereco = indice;

endmodule

// File: tb/tb_apresentador_pergunta.sv
// Self-checking bench for the question-presentation sequencer.
// Latency: checks cycle-exact timing against the per-entry cost formula.
// Backpressure: n/a.
module tb_apresentador_pergunta;
  import apresentador_pkg::*;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam int TON    = T_ON_SIM;
  localparam int TOFF   = T_OFF_SIM;
  localparam int P      = TON + TOFF + 3;

  logic              clock;
  logic              reset_n;
  logic              iniciar;
  logic              abortar;
  logic [ADDR_W-1:0] num_itens;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] dado_rom;
  logic [DATA_W-1:0] leds;
  logic              led_ativo;
  logic              ocupado;
  logic              pronto;
  logic [3:0]        db_estado;

  int n_assert;
  int n_falhas;
  int esperado_q[$];

  apresentador_pergunta #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .T_ON  (TON),
    .T_OFF (TOFF)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .iniciar  (iniciar),
    .abortar  (abortar),
    .num_itens(num_itens),
    .endereco (endereco),
    .dado_rom (dado_rom),
    .leds     (leds),
    .led_ativo(led_ativo),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM contents: 1,2,4,8 at addresses 0..3, address value elsewhere.
  function automatic logic [DATA_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] um;
    um = 1;
    if (a < 4) return um << a;
    return a;
  endfunction

  // Synchronous ROM, one cycle read latency.
  always @(posedge clock) dado_rom <= rom_val(endereco);

  task automatic confere(input string tag, input int obs, input int esp);
    n_assert++;
    if (obs != esp) begin
      n_falhas++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, esp, $time);
    end
  endtask

  // Drive one sequence starting at the current negedge (cycle 0) and check every cycle.
  task automatic run_seq(input int n_last, input int abort_at, input int pulse_at, input bit hold);
    int n;
    int fim_c;
    int last_c;
    int e_st, e_end, e_leds, e_oc, e_pr;
    int i, k, item;
    bit chk_end;
    logic prev_at;
    n      = n_last + 1;
    fim_c  = n * P + 1;
    last_c = (abort_at != 0) ? abort_at + 1 : fim_c + 1;
    for (int j = 0; j < n; j++) begin
      if (abort_at == 0 || (3 + P * j) <= abort_at)
        esperado_q.push_back(j * 16 + int'(rom_val(ADDR_W'(j))));
    end
    num_itens = ADDR_W'(n_last);
    iniciar   = 1'b1;
    abortar   = 1'b0;
    prev_at   = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clock);
      e_st = 0; e_end = 0; e_leds = 0; e_oc = 0; e_pr = 0; chk_end = 1'b0;
      if (abort_at != 0 && c > abort_at) begin
        e_st = 0;
      end else if (c <= n * P) begin
        i = (c - 1) / P;
        k = (c - 1) % P;
        e_oc = 1; e_end = i; chk_end = 1'b1;
        if (k == 0)                  e_st = 1;
        else if (k == 1)             e_st = 2;
        else if (k < 2 + TON)        begin e_st = 3; e_leds = int'(rom_val(ADDR_W'(i))); end
        else if (k < 2 + TON + TOFF) e_st = 4;
        else                         e_st = 5;
      end else if (c == fim_c) begin
        e_st = 6; e_oc = 1; e_pr = 1; e_end = n_last; chk_end = 1'b1;
      end
      confere("db_estado", db_estado, e_st);
      confere("leds", leds, e_leds);
      confere("led_ativo", led_ativo, (e_st == 3) ? 1 : 0);
      confere("ocupado", ocupado, e_oc);
      confere("pronto", pronto, e_pr);
      if (chk_end) confere("endereco", endereco, e_end);
      if (led_ativo && !prev_at) begin
        if (esperado_q.size() == 0) begin
          confere("sb_inesperado", 1, 0);
        end else begin
          item = esperado_q.pop_front();
          confere("sb_endereco", endereco, item / 16);
          confere("sb_leds", leds, item % 16);
        end
      end
      prev_at = led_ativo;
      // Inputs for the edge that ends this cycle.
      if (!hold) iniciar = (c == pulse_at);
      abortar = (c == abort_at);
      num_itens = (c == last_c) ? '0 : ADDR_W'($urandom_range(0, 15));
    end
    abortar = 1'b0;
    if (!hold) iniciar = 1'b0;
    if (hold) begin
      @(negedge clock);
      confere("restart_busca", db_estado, 1);
      confere("restart_endereco", endereco, 0);
      confere("restart_ocupado", ocupado, 1);
      iniciar = 1'b0;
      abortar = 1'b1;
      @(negedge clock);
      confere("restart_abort", db_estado, 0);
      confere("restart_leds", leds, 0);
      abortar = 1'b0;
    end
    confere("sb_restante", esperado_q.size(), 0);
    esperado_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert  = 0;
    n_falhas  = 0;
    reset_n   = 1'b0;
    iniciar   = 1'b0;
    abortar   = 1'b0;
    num_itens = '0;
    #2;
    confere("rst_db", db_estado, 0);
    confere("rst_leds", leds, 0);
    confere("rst_ocupado", ocupado, 0);
    confere("rst_endereco", endereco, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    confere("pos_rst_db", db_estado, 0);

    run_seq(0, 0, 0, 1'b0);    // single entry
    run_seq(2, 0, 0, 1'b0);    // three entries
    run_seq(2, 12, 0, 1'b0);   // abort during second LIGA
    run_seq(0, 0, 0, 1'b0);    // fresh start after abort
    run_seq(0, 0, 5, 1'b0);    // iniciar while busy is ignored
    run_seq(0, 0, 0, 1'b1);    // iniciar held: restart
    run_seq(15, 0, 0, 1'b0);   // full address range, no wrap

    // abortar together with iniciar in OCIOSO: stay idle.
    iniciar = 1'b1;
    abortar = 1'b1;
    @(negedge clock);
    confere("abort_vence", db_estado, 0);
    confere("abort_vence_ocupado", ocupado, 0);
    iniciar = 1'b0;
    abortar = 1'b0;

    // Asynchronous reset during LIGA.
    iniciar   = 1'b1;
    num_itens = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      iniciar = 1'b0;
    end
    confere("pre_rst_liga", db_estado, 3);
    #1;
    reset_n = 1'b0;
    #1;
    confere("arst_db", db_estado, 0);
    confere("arst_leds", leds, 0);
    confere("arst_led_ativo", led_ativo, 0);
    confere("arst_ocupado", ocupado, 0);
    confere("arst_pronto", pronto, 0);
    confere("arst_endereco", endereco, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      confere("arst_ocioso", db_estado, 0);
      confere("arst_sem_pronto", pronto, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_falhas);
    $finish;
  end

endmodule
